// File: rtl/led_blink_decoder_if.sv
// Pin bundle between the LED/opto receive pads and the blink-code decoder.
// Optional BCD digit outputs are present only when BCD_OUT_EN is defined.
interface led_blink_decoder_if;
  logic       BLINK_G;
  logic       BLINK_R;
  logic [4:0] HOUR;
  logic [4:0] DAY;
  logic       HOUR_VLD;
  logic       DAY_VLD;
  logic       HOUR_ERR;
  logic       DAY_ERR;
  logic       BUSY;
`ifdef BCD_OUT_EN
  logic [3:0] SEG4;
  logic [3:0] SEG5;
  logic [3:0] SEG6;
  logic [3:0] SEG7;

  modport master (
    output BLINK_G, BLINK_R,
    input  HOUR, DAY, HOUR_VLD, DAY_VLD, HOUR_ERR, DAY_ERR, BUSY,
    input  SEG4, SEG5, SEG6, SEG7
  );
  modport slave (
    input  BLINK_G, BLINK_R,
    output HOUR, DAY, HOUR_VLD, DAY_VLD, HOUR_ERR, DAY_ERR, BUSY,
    output SEG4, SEG5, SEG6, SEG7
  );
`else
  modport master (
    output BLINK_G, BLINK_R,
    input  HOUR, DAY, HOUR_VLD, DAY_VLD, HOUR_ERR, DAY_ERR, BUSY
  );
  modport slave (
    input  BLINK_G, BLINK_R,
    output HOUR, DAY, HOUR_VLD, DAY_VLD, HOUR_ERR, DAY_ERR, BUSY
  );
`endif
endinterface

// File: rtl/led_blink_decoder.sv
// LED blink-code receiver: green stream -> HOUR, red stream -> DAY.
// Each value unit is one 500 ms high / 500 ms low period on the 1 kHz clock;
// a long low gap ends a frame. Two independent channel engines do the work.
// Optional macro BCD_OUT_EN adds registered BCD digits SEG4..SEG7.

// One decoding channel: synchronizer, edge detector and frame state machine.
module led_blink_channel #(
  parameter int HALF_MIN = 400,
  parameter int HALF_MAX = 600,
  parameter int GAP      = 1500,
  parameter int LIMIT    = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       blink,
  output logic [4:0] value,
  output logic       vld,
  output logic       err,
  output logic       busy
`ifdef BCD_OUT_EN
  ,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens
`endif
);
  // Phase counter is sized to hold the frame gap, which exceeds 10 bits.
  localparam int PW = $clog2(GAP + 1);
  localparam logic [PW-1:0] HALF_MIN_C = PW'(HALF_MIN);
  localparam logic [PW-1:0] HIGH_OVF_C = PW'(HALF_MAX + 1);
  localparam logic [PW-1:0] GAP_C      = PW'(GAP);
  localparam logic [PW-1:0] ONE_C      = PW'(1);
  localparam logic [5:0]    LIMIT_C    = 6'(LIMIT);
  localparam logic [5:0]    OVF_C      = 6'(LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE,
    S_RECOVER
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d, pcnt_inc;
  logic [5:0]    ncnt_q, ncnt_d, ncnt_inc;
  logic [4:0]    value_q, value_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic          level, rise, fall;

  assign sync_d = {sync_q[0], blink};
  assign prev_d = sync_q[1];
  assign level  = sync_q[1];
  assign rise   = level & ~prev_q;
  assign fall   = ~level & prev_q;

  // Synchronizer, edge history and all channel state.
  // NOTE: every flop, including the synchronizer, clears on the async reset so a stuck-high input reads as a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      state_q <= S_IDLE;
      pcnt_q  <= '0;
      ncnt_q  <= '0;
      value_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      ncnt_q  <= ncnt_d;
      value_q <= value_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counters and pulse outputs for the frame state machine.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    ncnt_d   = ncnt_q;
    value_d  = value_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    pcnt_inc = pcnt_q + ONE_C;
    ncnt_inc = ncnt_q + 6'd1;
    unique case (state_q)
      S_IDLE: begin
        pcnt_d = '0;
        ncnt_d = '0;
        if (rise) begin
          state_d = S_HIGH;
          pcnt_d  = ONE_C;
        end
      end
      S_HIGH: begin
        if (fall) begin
          if (pcnt_q >= HALF_MIN_C) begin
            if (ncnt_inc == OVF_C) begin
              // Too many pulses for this channel: give up on the frame now.
              err_d   = 1'b1;
              ncnt_d  = '0;
              pcnt_d  = '0;
              state_d = S_RECOVER;
            end else begin
              ncnt_d  = ncnt_inc;
              pcnt_d  = ONE_C;
              state_d = S_LOW;
            end
          end else begin
            err_d   = 1'b1;
            ncnt_d  = '0;
            pcnt_d  = '0;
            state_d = S_IDLE;
          end
        end else if (pcnt_inc == HIGH_OVF_C) begin
          err_d   = 1'b1;
          ncnt_d  = '0;
          pcnt_d  = '0;
          state_d = S_RECOVER;
        end else begin
          pcnt_d = pcnt_inc;
        end
      end
      S_LOW: begin
        if (rise) begin
          if (pcnt_q >= HALF_MIN_C) begin
            pcnt_d  = ONE_C;
            state_d = S_HIGH;
          end else begin
            err_d   = 1'b1;
            ncnt_d  = '0;
            pcnt_d  = '0;
            state_d = S_RECOVER;
          end
        end else if (pcnt_inc >= GAP_C) begin
          pcnt_d  = GAP_C;
          state_d = S_DONE;
        end else begin
          pcnt_d = pcnt_inc;
        end
      end
      S_DONE: begin
        if (ncnt_q <= LIMIT_C) begin
          value_d = ncnt_q[4:0];
          vld_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        ncnt_d  = '0;
        pcnt_d  = '0;
        state_d = S_IDLE;
      end
      S_RECOVER: begin
        // Reuse the phase counter as a consecutive-low counter.
        ncnt_d = '0;
        if (level) begin
          pcnt_d = '0;
        end else if (pcnt_inc >= HALF_MIN_C) begin
          pcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          pcnt_d = pcnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        pcnt_d  = '0;
        ncnt_d  = '0;
      end
    endcase
  end

  assign value = value_q;
  assign vld   = vld_q;
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);

`ifdef BCD_OUT_EN
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [4:0] rem;

  // Split the next value into tens/ones so the digits load with the value.
  always_comb begin
    tens_d = 4'd0;
    rem    = value_d;
    if (value_d >= 5'd30) begin
      tens_d = 4'd3;
      rem    = value_d - 5'd30;
    end else if (value_d >= 5'd20) begin
      tens_d = 4'd2;
      rem    = value_d - 5'd20;
    end else if (value_d >= 5'd10) begin
      tens_d = 4'd1;
      rem    = value_d - 5'd10;
    end
    ones_d = rem[3:0];
  end

  // BCD digit registers, updated in lockstep with the binary value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign bcd_ones = ones_q;
  assign bcd_tens = tens_q;
`endif
endmodule

// Top level: green channel decodes HOUR, red channel decodes DAY.
module led_blink_decoder #(
  parameter int HALF_MIN   = 400,
  parameter int HALF_MAX   = 600,
  parameter int GAP        = 1500,
  parameter int HOUR_LIMIT = 23
) (
  input logic                 CLK1K,
  input logic                 RST,
  led_blink_decoder_if.slave  bus
);
  logic g_busy;
  logic r_busy;

  led_blink_channel #(
    .HALF_MIN (HALF_MIN),
    .HALF_MAX (HALF_MAX),
    .GAP      (GAP),
    .LIMIT    (HOUR_LIMIT)
  ) u_hour (
    .clk      (CLK1K),
    .rst      (RST),
    .blink    (bus.BLINK_G),
    .value    (bus.HOUR),
    .vld      (bus.HOUR_VLD),
    .err      (bus.HOUR_ERR),
    .busy     (g_busy)
`ifdef BCD_OUT_EN
    ,
    .bcd_ones (bus.SEG4),
    .bcd_tens (bus.SEG5)
`endif
  );

  led_blink_channel #(
    .HALF_MIN (HALF_MIN),
    .HALF_MAX (HALF_MAX),
    .GAP      (GAP),
    .LIMIT    (31)
  ) u_day (
    .clk      (CLK1K),
    .rst      (RST),
    .blink    (bus.BLINK_R),
    .value    (bus.DAY),
    .vld      (bus.DAY_VLD),
    .err      (bus.DAY_ERR),
    .busy     (r_busy)
`ifdef BCD_OUT_EN
    ,
    .bcd_ones (bus.SEG6),
    .bcd_tens (bus.SEG7)
`endif
  );

  assign bus.BUSY = g_busy | r_busy;
endmodule
